// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - single-car elevator controller with latched calls and directional sweep
module elevator_ctrl #(
  parameter int N_PISOS      = 4,
  parameter int W            = 2,
  parameter int T_PISO       = 50000000,
  parameter int T_PUERTA     = 100000000,
  parameter int PISO_INICIAL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PISOS-1:0] llamada,
  output logic [W-1:0]       piso,
  output logic [1:0]         direccion,
  output logic               puertas_abiertas,
  output logic               ocupado,
  output logic [N_PISOS-1:0] pendientes
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVER  = 2'd1,
    PUERTA = 2'd2
  } state_t;

  localparam logic            DIR_UP      = 1'b0;
  localparam logic            DIR_DOWN    = 1'b1;
  localparam logic [31:0]     T_PISO_M1   = T_PISO - 1;
  localparam logic [31:0]     T_PUERTA_M1 = T_PUERTA - 1;
  localparam logic [W-1:0]    PISO_INI    = W'(PISO_INICIAL);

  state_t             state, state_nx;
  logic [W-1:0]       piso_nx, piso_step;
  logic [N_PISOS-1:0] pend_nx, clr, lat;
  logic               ult_dir, ult_dir_nx;
  logic [31:0]        cnt, cnt_nx;
  logic               up_req, down_req, ahead;

  // Scan the pending mask for requests above and below the current floor
  always_comb begin
    up_req   = 1'b0;
    down_req = 1'b0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (pendientes[i]) begin
        if (i > int'(piso)) up_req = 1'b1;
        if (i < int'(piso)) down_req = 1'b1;
      end
    end
  end

  // Neighbouring floor in the travel direction and whether work remains that way
  always_comb begin
    piso_step = (ult_dir == DIR_UP) ? piso + W'(1) : piso - W'(1);
    ahead     = (ult_dir == DIR_UP) ? up_req : down_req;
  end

  // Next-state, counter, floor and pending-mask logic
  always_comb begin
    state_nx   = state;
    piso_nx    = piso;
    ult_dir_nx = ult_dir;
    cnt_nx     = cnt + 32'd1;
    clr        = '0;
    lat        = llamada;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (pendientes[piso]) begin
          state_nx   = PUERTA;
          clr[piso]  = 1'b1;
        end else if (|pendientes) begin
          state_nx = MOVER;
          if (ult_dir == DIR_UP) ult_dir_nx = up_req ? DIR_UP : DIR_DOWN;
          else                   ult_dir_nx = down_req ? DIR_DOWN : DIR_UP;
        end
      end
      MOVER: begin
        if (cnt == T_PISO_M1) begin
          cnt_nx  = '0;
          piso_nx = piso_step;
          if (pendientes[piso_step]) begin
            state_nx       = PUERTA;
            clr[piso_step] = 1'b1;
          end else if (!ahead) begin
            // Nothing left beyond this floor: stop rather than run off the shaft
            state_nx = IDLE;
          end
        end
      end
      PUERTA: begin
        // A call for the floor being served only holds the doors open
        lat[piso] = 1'b0;
        if (llamada[piso]) begin
          cnt_nx = '0;
        end else if (cnt == T_PUERTA_M1) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    // Clearing after OR-ing makes a same-edge call for the served floor lose
    pend_nx = (pendientes | lat) & ~clr;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      piso       <= PISO_INI;
      pendientes <= '0;
      ult_dir    <= DIR_UP;
      cnt        <= '0;
    end else begin
      state      <= state_nx;
      piso       <= piso_nx;
      pendientes <= pend_nx;
      ult_dir    <= ult_dir_nx;
      cnt        <= cnt_nx;
    end
  end

  // Outputs decoded from the state; direction is shown only while travelling
  always_comb begin
    direccion        = 2'b00;
    puertas_abiertas = 1'b0;
    ocupado          = 1'b0;
    case (state)
      MOVER: begin
        ocupado   = 1'b1;
        direccion = (ult_dir == DIR_UP) ? 2'b01 : 2'b10;
      end
      PUERTA: begin
        ocupado          = 1'b1;
        puertas_abiertas = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
